// File: rtl/minesweeper_pkg.sv
// Shared definitions for the minesweeper board engines: state encodings,
// the neighbour offset table, default board size and coordinate widths.
package minesweeper_pkg;

    localparam int defaultBoardWidth  = 8;
    localparam int defaultBoardHeight = 8;

    // Index of the last entry in the neighbour offset table.
    localparam logic [2:0] lastNeighbour = 3'd7;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_CLICK = 3'd1,
        ST_POP   = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DONE  = 3'd4,
        ST_SWEEP = 3'd5
    } revealState_t;

    // Bits needed to address one coordinate of a board dimension.
    function automatic int coordWidth(input int extent);
        return (extent > 1) ? $clog2(extent) : 1;
    endfunction

    // Bits needed to count from 0 up to and including 'cells'.
    function automatic int countWidth(input int cells);
        return $clog2(cells + 1);
    endfunction

    // Column offset of neighbour 'idx'; order is row above, same row, row below,
    // each scanned left to right.
    function automatic logic signed [1:0] neighbourDx(input logic [2:0] idx);
        logic signed [1:0] dx;
        case (idx)
            3'd0, 3'd3, 3'd5: dx = -2'sd1;
            3'd1, 3'd6:       dx = 2'sd0;
            default:          dx = 2'sd1;
        endcase
        return dx;
    endfunction

    // Row offset of neighbour 'idx'.
    function automatic logic signed [1:0] neighbourDy(input logic [2:0] idx);
        logic signed [1:0] dy;
        case (idx)
            3'd0, 3'd1, 3'd2: dy = -2'sd1;
            3'd3, 3'd4:       dy = 2'sd0;
            default:          dy = 2'sd1;
        endcase
        return dy;
    endfunction

endpackage

// File: rtl/coord_stack.sv
// LIFO of {x,y} board coordinates used by the flood fill.
// Synchronous push/pop, combinational top, sticky overflow flag.
module coord_stack
    import minesweeper_pkg::*;
#(
    parameter int depth  = 64,
    parameter int xWidth = 3,
    parameter int yWidth = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [xWidth-1:0] pushX,
    input  logic [yWidth-1:0] pushY,
    output logic [xWidth-1:0] topX,
    output logic [yWidth-1:0] topY,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam int ptrWidth  = countWidth(depth);
    localparam int addrWidth = coordWidth(depth);
    localparam logic [ptrWidth-1:0] depthCount = ptrWidth'(depth);

    logic [xWidth+yWidth-1:0] entries_r [depth];
    logic [ptrWidth-1:0]      count_r;
    logic                     overflow_r;
    logic                     doPush_s;
    logic                     doPop_s;
    logic [addrWidth-1:0]     topIdx_s;
    logic [addrWidth-1:0]     wrIdx_s;

    assign empty    = (count_r == {ptrWidth{1'b0}});
    assign full     = (count_r == depthCount);
    assign overflow = overflow_r;
    assign topX     = entries_r[topIdx_s][xWidth+yWidth-1:yWidth];
    assign topY     = entries_r[topIdx_s][yWidth-1:0];

    // Resolve which operation takes effect and where a pushed entry lands.
    always_comb begin
        doPop_s  = pop && !empty;
        doPush_s = push && (!full || doPop_s);
        if (empty) begin
            topIdx_s = {addrWidth{1'b0}};
        end else begin
            topIdx_s = addrWidth'(count_r - ptrWidth'(1));
        end
        if (doPop_s) begin
            wrIdx_s = topIdx_s;
        end else begin
            wrIdx_s = addrWidth'(count_r);
        end
    end

    // Entry storage; the occupancy count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (doPush_s) begin
            entries_r[wrIdx_s] <= {pushX, pushY};
        end
    end

    // Occupancy count and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r    <= {ptrWidth{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            count_r <= count_r + ptrWidth'(doPush_s) - ptrWidth'(doPop_s);
            if (push && full && !doPop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/reveal_cells_checker.sv
// Run-time checks for reveal_cells: stack never overflows, state flags one-hot.
module reveal_cells_checker #(
    parameter int numFlags = 5
) (
    input logic                clk,
    input logic                reset,
    input logic                stackPush,
    input logic                stackFull,
    input logic                stackOverflow,
    input logic [numFlags-1:0] stateFlags
);

    // Each cell is pushed at most once, so a push into a full stack means lost work.
    noPushWhenFull: assert property (@(posedge clk) disable iff (!reset)
        !(stackPush && stackFull));

    noOverflow: assert property (@(posedge clk) disable iff (!reset)
        !stackOverflow);

    stateOneHot: assert property (@(posedge clk) disable iff (!reset)
        $onehot(stateFlags));

endmodule

// File: rtl/reveal_cells.sv
// Reveal engine: handles one player click against the mine/adjacency boards,
// flood-fills zero-adjacency regions with an explicit coordinate stack and
// writes the revealed board.
// Optional build macro REVEAL_ALL_MINES_ON_HIT_EN: after a mine hit, sweep the
// whole board and reveal every mine before reporting done (adds qSweep).
module reveal_cells
    import minesweeper_pkg::*;
#(
    parameter int boardWidth  = defaultBoardWidth,
    parameter int boardHeight = defaultBoardHeight,
    parameter int stackDepth  = boardWidth * boardHeight
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic                                          ack,
    input  logic [coordWidth(boardWidth)-1:0]             clickX,
    input  logic [coordWidth(boardHeight)-1:0]            clickY,
    output logic [coordWidth(boardWidth)-1:0]             readX,
    output logic [coordWidth(boardHeight)-1:0]            readY,
    input  logic                                          mineReadValue,
    input  logic [3:0]                                    adjReadValue,
    input  logic                                          revealedReadValue,
    output logic                                          revealEn,
    output logic [coordWidth(boardWidth)-1:0]             revealX,
    output logic [coordWidth(boardHeight)-1:0]            revealY,
    output logic                                          hitMine,
    output logic [countWidth(boardWidth*boardHeight)-1:0] cellsRevealed,
    output logic                                          qInit,
    output logic                                          qClick,
    output logic                                          qPop,
    output logic                                          qScan,
    output logic                                          done
`ifdef REVEAL_ALL_MINES_ON_HIT_EN
    ,
    output logic                                          qSweep
`endif
);

    localparam int xW   = coordWidth(boardWidth);
    localparam int yW   = coordWidth(boardHeight);
    localparam int cntW = countWidth(boardWidth * boardHeight);

    localparam logic signed [xW+1:0] xLimit = (xW + 2)'(boardWidth);
    localparam logic signed [yW+1:0] yLimit = (yW + 2)'(boardHeight);

`ifdef REVEAL_ALL_MINES_ON_HIT_EN
    localparam revealState_t hitNext = ST_SWEEP;
    localparam int numFlags = 6;
    localparam logic [xW-1:0] lastX = xW'(boardWidth - 1);
    localparam logic [yW-1:0] lastY = yW'(boardHeight - 1);
`else
    localparam revealState_t hitNext = ST_DONE;
    localparam int numFlags = 5;
`endif

    revealState_t         state_r;
    revealState_t         nextState_s;
    logic [xW-1:0]        curX_r;
    logic [yW-1:0]        curY_r;
    logic [2:0]           nbrIdx_r;
    logic                 hitMine_r;
    logic [cntW-1:0]      count_r;

    logic signed [1:0]    offX_s;
    logic signed [1:0]    offY_s;
    logic signed [xW+1:0] probeX_s;
    logic signed [yW+1:0] probeY_s;
    logic                 probeInside_s;
    logic [xW-1:0]        readX_s;
    logic [yW-1:0]        readY_s;

    logic                 revealEn_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 countInc_s;
    logic                 setHit_s;

    logic [xW-1:0]        stackTopX_s;
    logic [yW-1:0]        stackTopY_s;
    logic                 stackEmpty_s;
    logic                 stackFull_s;
    logic                 stackOverflow_s;
    logic [numFlags-1:0]  flags_s;

`ifdef REVEAL_ALL_MINES_ON_HIT_EN
    logic [xW-1:0]        sweepX_r;
    logic [yW-1:0]        sweepY_r;
`endif

    // Probe coordinate: the current cell plus the active neighbour offset (zero outside SCAN).
    always_comb begin
        if (state_r == ST_SCAN) begin
            offX_s = neighbourDx(nbrIdx_r);
            offY_s = neighbourDy(nbrIdx_r);
        end else begin
            offX_s = 2'sd0;
            offY_s = 2'sd0;
        end
        probeX_s = $signed({2'b00, curX_r}) + $signed({{xW{offX_s[1]}}, offX_s});
        probeY_s = $signed({2'b00, curY_r}) + $signed({{yW{offY_s[1]}}, offY_s});
        probeInside_s = !probeX_s[xW+1] && (probeX_s < xLimit) &&
                        !probeY_s[yW+1] && (probeY_s < yLimit);
`ifdef REVEAL_ALL_MINES_ON_HIT_EN
        if (state_r == ST_SWEEP) begin
            readX_s = sweepX_r;
            readY_s = sweepY_r;
        end else begin
            readX_s = probeX_s[xW-1:0];
            readY_s = probeY_s[yW-1:0];
        end
`else
        readX_s = probeX_s[xW-1:0];
        readY_s = probeY_s[yW-1:0];
`endif
    end

    assign readX   = readX_s;
    assign readY   = readY_s;
    assign revealX = readX_s;
    assign revealY = readY_s;
    assign revealEn = revealEn_s;

    // Next-state and per-cycle control strobes.
    always_comb begin
        nextState_s = state_r;
        revealEn_s  = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        countInc_s  = 1'b0;
        setHit_s    = 1'b0;
        case (state_r)
            ST_INIT: begin
                if (start) begin
                    nextState_s = ST_CLICK;
                end else begin
                    nextState_s = ST_INIT;
                end
            end
            ST_CLICK: begin
                if (!probeInside_s || revealedReadValue) begin
                    nextState_s = ST_DONE;
                end else begin
                    revealEn_s = 1'b1;
                    countInc_s = 1'b1;
                    if (mineReadValue) begin
                        setHit_s    = 1'b1;
                        nextState_s = hitNext;
                    end else if (adjReadValue == 4'd0) begin
                        push_s      = 1'b1;
                        nextState_s = ST_POP;
                    end else begin
                        nextState_s = ST_DONE;
                    end
                end
            end
            ST_POP: begin
                if (stackEmpty_s) begin
                    nextState_s = ST_DONE;
                end else begin
                    pop_s       = 1'b1;
                    nextState_s = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Marking at push time keeps every cell on the stack at most once.
                if (probeInside_s && !revealedReadValue && !mineReadValue) begin
                    revealEn_s = 1'b1;
                    countInc_s = 1'b1;
                    push_s     = (adjReadValue == 4'd0);
                end else begin
                    revealEn_s = 1'b0;
                end
                if (nbrIdx_r == lastNeighbour) begin
                    nextState_s = ST_POP;
                end else begin
                    nextState_s = ST_SCAN;
                end
            end
            ST_DONE: begin
                if (ack) begin
                    nextState_s = ST_INIT;
                end else begin
                    nextState_s = ST_DONE;
                end
            end
`ifdef REVEAL_ALL_MINES_ON_HIT_EN
            ST_SWEEP: begin
                revealEn_s = mineReadValue && !revealedReadValue;
                if ((sweepX_r == lastX) && (sweepY_r == lastY)) begin
                    nextState_s = ST_DONE;
                end else begin
                    nextState_s = ST_SWEEP;
                end
            end
`endif
            default: begin
                nextState_s = ST_INIT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Current cell, neighbour index and the reported results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curX_r    <= {xW{1'b0}};
            curY_r    <= {yW{1'b0}};
            nbrIdx_r  <= 3'd0;
            hitMine_r <= 1'b0;
            count_r   <= {cntW{1'b0}};
        end else if ((state_r == ST_INIT) && start) begin
            curX_r    <= clickX;
            curY_r    <= clickY;
            hitMine_r <= 1'b0;
            count_r   <= {cntW{1'b0}};
        end else begin
            if (setHit_s) begin
                hitMine_r <= 1'b1;
            end
            if (countInc_s) begin
                count_r <= count_r + cntW'(1);
            end
            if (pop_s) begin
                curX_r   <= stackTopX_s;
                curY_r   <= stackTopY_s;
                nbrIdx_r <= 3'd0;
            end else if (state_r == ST_SCAN) begin
                nbrIdx_r <= nbrIdx_r + 3'd1;
            end
        end
    end

`ifdef REVEAL_ALL_MINES_ON_HIT_EN
    // Raster position of the post-hit mine sweep; parked at (0,0) outside SWEEP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sweepX_r <= {xW{1'b0}};
            sweepY_r <= {yW{1'b0}};
        end else if (state_r != ST_SWEEP) begin
            sweepX_r <= {xW{1'b0}};
            sweepY_r <= {yW{1'b0}};
        end else if (sweepX_r == lastX) begin
            sweepX_r <= {xW{1'b0}};
            sweepY_r <= sweepY_r + yW'(1);
        end else begin
            sweepX_r <= sweepX_r + xW'(1);
        end
    end

    assign qSweep = (state_r == ST_SWEEP);
    assign flags_s = {qInit, qClick, qPop, qScan, done, qSweep};
`else
    assign flags_s = {qInit, qClick, qPop, qScan, done};
`endif

    assign hitMine       = hitMine_r;
    assign cellsRevealed = count_r;
    assign qInit         = (state_r == ST_INIT);
    assign qClick        = (state_r == ST_CLICK);
    assign qPop          = (state_r == ST_POP);
    assign qScan         = (state_r == ST_SCAN);
    assign done          = (state_r == ST_DONE);

    coord_stack #(
        .depth (stackDepth),
        .xWidth(xW),
        .yWidth(yW)
    ) stack_u (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .pop     (pop_s),
        .pushX   (probeX_s[xW-1:0]),
        .pushY   (probeY_s[yW-1:0]),
        .topX    (stackTopX_s),
        .topY    (stackTopY_s),
        .empty   (stackEmpty_s),
        .full    (stackFull_s),
        .overflow(stackOverflow_s)
    );

    reveal_cells_checker #(
        .numFlags(numFlags)
    ) checker_u (
        .clk          (clk),
        .reset        (reset),
        .stackPush    (push_s),
        .stackFull    (stackFull_s),
        .stackOverflow(stackOverflow_s),
        .stateFlags   (flags_s)
    );

endmodule

// File: tb/tb_reveal_cells.sv
// Testbench for reveal_cells: directed table of board scenarios, hand-written
// DONE/ack and mid-flood reset sequences, and random boards checked against a
// breadth-first reference of the reveal rules.
module tb_reveal_cells;

    localparam int W     = 8;
    localparam int H     = 8;
    localparam int CELLS = W * H;

    logic       clk_tb;
    logic       reset_tb;
    logic       start;
    logic       ack;
    logic [2:0] clickX, clickY, readX, readY, revealX, revealY;
    logic       mineReadValue, revealedReadValue, revealEn, hitMine;
    logic [3:0] adjReadValue;
    logic [6:0] cellsRevealed;
    logic       qInit, qClick, qPop, qScan, done;
`ifdef REVEAL_ALL_MINES_ON_HIT_EN
    logic       qSweep;
`endif

    logic [63:0] mineB;
    logic [63:0] revB;
    logic [63:0] preloadVal;
    logic        preloadReq;
    logic [3:0]  adjB [CELLS];
    int          pulseCount;
    int          mineWrites;
    int          vectors;
    int          miscompares;

    reveal_cells #(.boardWidth(W), .boardHeight(H)) dut (
        .clk(clk_tb), .reset(reset_tb), .start(start), .ack(ack),
        .clickX(clickX), .clickY(clickY), .readX(readX), .readY(readY),
        .mineReadValue(mineReadValue), .adjReadValue(adjReadValue),
        .revealedReadValue(revealedReadValue), .revealEn(revealEn),
        .revealX(revealX), .revealY(revealY), .hitMine(hitMine),
        .cellsRevealed(cellsRevealed), .qInit(qInit), .qClick(qClick),
        .qPop(qPop), .qScan(qScan), .done(done)
`ifdef REVEAL_ALL_MINES_ON_HIT_EN
        , .qSweep(qSweep)
`endif
    );

    initial begin
        clk_tb = 1'b0;
        forever #5 clk_tb = ~clk_tb;
    end

    assign mineReadValue     = mineB[{readY, readX}];
    assign adjReadValue      = adjB[{readY, readX}];
    assign revealedReadValue = revB[{readY, readX}];

    // Revealed-board memory plus write bookkeeping.
    always @(posedge clk_tb) begin
        if (preloadReq) begin
            revB       <= preloadVal;
            pulseCount <= 0;
            mineWrites <= 0;
        end else if (revealEn) begin
            revB[{revealY, revealX}] <= 1'b1;
            pulseCount <= pulseCount + 1;
            if (mineB[{revealY, revealX}]) mineWrites <= mineWrites + 1;
        end
    end

    function automatic int cellIdx(input int x, input int y);
        return y * W + x;
    endfunction

    function automatic int adjOf(input logic [63:0] m, input int x, input int y);
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < W &&
                    y + dy >= 0 && y + dy < H && m[cellIdx(x + dx, y + dy)])
                    n++;
        return n;
    endfunction

    // Reference: breadth-first expansion of the reveal rules.
    function automatic void refModel(input logic [63:0] mines, input logic [63:0] pre,
                                     input int cx, input int cy,
                                     output logic [63:0] rev, output int cnt,
                                     output logic hit, output int lat);
        int q[$];
        int pushes, c, x, y, nx, ny;
        rev = pre; cnt = 0; hit = 1'b0; pushes = 0;
        if (!rev[cellIdx(cx, cy)]) begin
            rev[cellIdx(cx, cy)] = 1'b1;
            cnt = 1;
            if (mines[cellIdx(cx, cy)]) hit = 1'b1;
            else if (adjOf(mines, cx, cy) == 0) begin q.push_back(cellIdx(cx, cy)); pushes++; end
        end
        while (q.size() > 0) begin
            c = q.pop_front();
            x = c % W; y = c / W;
            for (int dy = -1; dy <= 1; dy++)
                for (int dx = -1; dx <= 1; dx++) begin
                    nx = x + dx; ny = y + dy;
                    if (!(dx == 0 && dy == 0) && nx >= 0 && nx < W && ny >= 0 && ny < H &&
                        !rev[cellIdx(nx, ny)] && !mines[cellIdx(nx, ny)]) begin
                        rev[cellIdx(nx, ny)] = 1'b1;
                        cnt++;
                        if (adjOf(mines, nx, ny) == 0) begin q.push_back(cellIdx(nx, ny)); pushes++; end
                    end
                end
        end
        lat = (pushes > 0) ? (3 + 9 * pushes) : 2;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic loadBoard(input logic [63:0] mines, input logic [63:0] pre);
        mineB = mines;
        for (int i = 0; i < CELLS; i++) adjB[i] = 4'(adjOf(mines, i % W, i / W));
        preloadVal = pre;
        preloadReq = 1'b1;
        @(posedge clk_tb);
        @(negedge clk_tb);
        preloadReq = 1'b0;
    endtask

    task automatic runClick(input string tag, input logic [63:0] mines, input logic [63:0] pre,
                            input int cx, input int cy, input logic expHit,
                            input int expCnt, input int expLat);
        logic [63:0] mRev;
        int          mCnt, mLat, cycles;
        logic        mHit;
        refModel(mines, pre, cx, cy, mRev, mCnt, mHit, mLat);
        loadBoard(mines, pre);
        clickX = 3'(cx); clickY = 3'(cy); start = 1'b1;
        @(posedge clk_tb);
        @(negedge clk_tb);
        start = 1'b0;
        cycles = 1;
        while (!done && cycles < 2000) begin
            @(posedge clk_tb); cycles++; @(negedge clk_tb);
        end
        check({tag, ".done"}, 64'(done), 64'd1);
        check({tag, ".latency"}, 64'(cycles), 64'(expLat));
        check({tag, ".hitMine"}, 64'(hitMine), 64'(expHit));
        check({tag, ".cellsRevealed"}, 64'(cellsRevealed), 64'(expCnt));
        check({tag, ".board"}, revB, mRev);
        check({tag, ".pulses"}, 64'(pulseCount), 64'(expCnt));
        check({tag, ".mineWrites"}, 64'(mineWrites), expHit ? 64'd1 : 64'd0);
        if (!done) begin
            reset_tb = 1'b0; @(negedge clk_tb); reset_tb = 1'b1; @(negedge clk_tb);
        end
    endtask

    task automatic doAck(input string tag);
        ack = 1'b1;
        @(posedge clk_tb);
        @(negedge clk_tb);
        ack = 1'b0;
        check({tag, ".ackToInit"}, 64'(qInit), 64'd1);
    endtask

    typedef struct {
        string       name;
        logic [63:0] mines;
        logic [63:0] pre;
        int          cx;
        int          cy;
        logic        expHit;
        int          expCnt;
        int          expLat;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vectors = 0; miscompares = 0;
        start = 1'b0; ack = 1'b0; clickX = 3'd0; clickY = 3'd0;
        preloadReq = 1'b0; preloadVal = 64'd0; mineB = 64'd0;
        for (int i = 0; i < CELLS; i++) adjB[i] = 4'd0;
        reset_tb = 1'b0;

        vecs[0] = '{"emptyFlood",  64'h0, 64'h0, 3, 3, 1'b0, 64, 579};
        vecs[1] = '{"mineClick",   64'h1, 64'h0, 0, 0, 1'b1, 1, 2};
        vecs[2] = '{"adjClick",    64'h1, 64'h0, 1, 1, 1'b0, 1, 2};
        vecs[3] = '{"preRevealed", 64'h0, 64'h0000000000040000, 2, 2, 1'b0, 0, 2};
        vecs[4] = '{"mineColumn",  64'h1010101010101010, 64'h0, 0, 0, 1'b0, 32, 219};

        repeat (3) @(negedge clk_tb);
        check("reset.qInit", 64'(qInit), 64'd1);
        check("reset.done", 64'(done), 64'd0);
        check("reset.hitMine", 64'(hitMine), 64'd0);
        check("reset.cellsRevealed", 64'(cellsRevealed), 64'd0);
        check("reset.revealEn", 64'(revealEn), 64'd0);
        reset_tb = 1'b1;
        @(negedge clk_tb);

        for (int i = 0; i < 5; i++) begin
            runClick(vecs[i].name, vecs[i].mines, vecs[i].pre, vecs[i].cx, vecs[i].cy,
                     vecs[i].expHit, vecs[i].expCnt, vecs[i].expLat);
            if (i == 1) begin
                // Results hold in DONE; start+ack together leaves via ack only.
                repeat (5) begin @(posedge clk_tb); @(negedge clk_tb); end
                check("hold.done", 64'(done), 64'd1);
                check("hold.hitMine", 64'(hitMine), 64'd1);
                check("hold.cellsRevealed", 64'(cellsRevealed), 64'd1);
                start = 1'b1; ack = 1'b1;
                @(posedge clk_tb); @(negedge clk_tb);
                start = 1'b0; ack = 1'b0;
                check("startAck.qInit", 64'(qInit), 64'd1);
                @(posedge clk_tb); @(negedge clk_tb);
                check("startAck.stayInit", 64'(qInit), 64'd1);
            end else begin
                doAck(vecs[i].name);
            end
        end

        // Reset in the middle of an empty-board flood.
        loadBoard(64'h0, 64'h0);
        clickX = 3'd3; clickY = 3'd3; start = 1'b1;
        @(posedge clk_tb); @(negedge clk_tb);
        start = 1'b0;
        repeat (39) begin @(posedge clk_tb); @(negedge clk_tb); end
        check("midReset.inScan", 64'(qScan), 64'd1);
        reset_tb = 1'b0;
        #1;
        check("midReset.qInit", 64'(qInit), 64'd1);
        check("midReset.qScan", 64'(qScan), 64'd0);
        check("midReset.revealEn", 64'(revealEn), 64'd0);
        check("midReset.hitMine", 64'(hitMine), 64'd0);
        check("midReset.cellsRevealed", 64'(cellsRevealed), 64'd0);
        @(negedge clk_tb);
        reset_tb = 1'b1;
        @(negedge clk_tb);
        runClick("afterReset", 64'h0, 64'h0, 7, 7, 1'b0, 64, 579);
        doAck("afterReset");

        // Random boards against the reference.
        for (int r = 0; r < 20; r++) begin
            logic [63:0] m, p, eRev;
            int dens, cx, cy, eCnt, eLat;
            logic eHit;
            dens = $urandom_range(0, 22);
            for (int i = 0; i < CELLS; i++) begin
                m[i] = ($urandom_range(0, 99) < dens);
                p[i] = ($urandom_range(0, 99) < 4);
            end
            cx = $urandom_range(0, W - 1);
            cy = $urandom_range(0, H - 1);
            refModel(m, p, cx, cy, eRev, eCnt, eHit, eLat);
            runClick($sformatf("rand%0d", r), m, p, cx, cy, eHit, eCnt, eLat);
            doAck($sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reveal_cells.md
Name: reveal_cells

Overview:
- Downstream consumer of the mine-placement stage. Takes a player click (x,y) and reads the mine board and the adjacency board that placement populated.
- Writes the 1-bit revealed board. On a zero-adjacency cell it performs an iterative flood-fill using an explicit coordinate stack.
- Reports whether a mine was hit and how many cells were newly revealed. Uses the same start/ack handshake and one-hot state outputs as placement.

Parameters:
- boardWidth, 8, board columns.
- boardHeight, 8, board rows.
- stackDepth, boardWidth*boardHeight, coordinate stack entries.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin reveal; sampled only in INIT.
- ack  in  1  leave DONE.
- clickX  in  $clog2(boardWidth)  clicked column.
- clickY  in  $clog2(boardHeight)  clicked row.
- readX  out  $clog2(boardWidth)  shared combinational read address to mine, adjacency and revealed boards.
- readY  out  $clog2(boardHeight)  shared read row.
- mineReadValue  in  1  mine board read data (combinational).
- adjReadValue  in  4  adjacency board read data (combinational).
- revealedReadValue  in  1  revealed board read data (combinational).
- revealEn  out  1  revealed-board write strobe; written value is always 1.
- revealX  out  $clog2(boardWidth)  write column.
- revealY  out  $clog2(boardHeight)  write row.
- hitMine  out  1  clicked cell was a mine.
- cellsRevealed  out  $clog2(boardWidth*boardHeight+1)  newly revealed count.
- qInit, qClick, qPop, qScan, done  out  1 each  one-hot state flags.

Behaviour:
- Reset (async, reset==0):
  - state INIT; stack emptied; hitMine=0; cellsRevealed=0; revealEn=0.
  - Reset mid-operation abandons the operation; revealed-board writes already made stay.
- INIT:
  - When start=1: latch click, clear hitMine and cellsRevealed, go to CLICK. start is ignored in other states.
- CLICK (1 cycle): read address = click.
  - Click out of range, or revealed=1: DONE, no write, count stays 0.
  - Otherwise revealEn=1 at the click and count=1.
  - mine=1: hitMine=1, go to DONE (or SWEEP, see Optional Feature).
  - adj==0: push click, go to POP.
  - Else: DONE.
- POP (1 cycle):
  - Stack empty: DONE.
  - Else pop top into cur, set n=0, go to SCAN.
- SCAN (8 cycles, n=0..7): neighbour offsets in order (-1,-1),(0,-1),(+1,-1),(-1,0),(+1,0),(-1,+1),(0,+1),(+1,+1).
  - Read address = cur + offset. Out of bounds: skipped, no wrap-around.
  - In bounds, revealed=0 and mine=0: revealEn=1 at that neighbour and count+1. If adj==0, also push the neighbour.
  - After n=7: go to POP.
- Cells are marked revealed at push time, so each cell is pushed at most once and stackDepth=W*H never overflows.
  - Push when full sets an internal sticky overflow and drops the entry. This is a verification assertion only.
- Write timing: revealed-board writes land at the next posedge; consecutive neighbours are distinct cells, so there is no read-after-write hazard.
- DONE: hitMine and cellsRevealed are held. ack=1 returns to INIT. start=1 and ack=1 in the same cycle: ack wins; start must be re-asserted in INIT.
- Latency: click on a revealed or non-zero cell is 2 cycles start→done. A flood with k pushed cells takes 2 + 9k + 1 cycles.
- Count width holds W*H without saturation.

Optional Feature:
- Macro: REVEAL_ALL_MINES_ON_HIT_EN.
- Defined: after a mine hit, go to state SWEEP instead of DONE.
  - SWEEP scans raster order (0,0)…(W-1,H-1), one cell per cycle, W*H cycles.
  - revealEn=1 on every mine cell not yet revealed. These reveals do not add to cellsRevealed.
  - Then DONE. qSweep is added as a one-hot output.
- Undefined: a hit goes directly to DONE; no SWEEP state or port.

Decomposition:
- Shared package minesweeper_pkg:
  - state encodings.
  - neighbour dx/dy offset table.
  - default board dimensions.
  - coordinate width functions.
- Sub-module coord_stack (LIFO of {x,y}): push, pop, empty, full, top. Synchronous write, combinational top, async active-low reset.

Test Plan:
- No mines, adj all 0, click (3,3) → all 64 cells revealed, cellsRevealed=64, hitMine=0, done 579 cycles after start.
- Mine at (0,0), click (0,0) → hitMine=1, cellsRevealed=1, exactly one revealEn pulse at (0,0).
- Mine at (0,0), click (1,1) (adj=1) → cellsRevealed=1, only (1,1) revealed, done 2 cycles after start.
- Pre-reveal (2,2), click (2,2) → cellsRevealed=0, zero revealEn pulses, hitMine=0.
- Mines on all of column x=4, click (0,0) → columns 0..3 revealed (32 cells), no mine cell written, hitMine=0.
- Assert reset during SCAN of the empty-board flood → all outputs at reset values immediately; a new start with click (7,7) on a fresh board reveals 64.
